// File: rtl/lb2apb_pkg.sv
// Shared types for the Local Bus to APB bridge: FSM state encoding and
// the APB transfer-direction values.
package lb2apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

endpackage : lb2apb_pkg

// File: rtl/lb2apb_bridge_if.sv
// Bus bundles for the bridge: the Local Bus request/response side and the
// APB side, each with master/slave modports.
interface lb_bus_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int STRB_W = DATA_W / 8
);
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wready;
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              err;
  logic              err_timeout;

  modport master (
    output wen, waddr, wdata, wstrb, ren, raddr,
    input  wready, rdata, rvalid, err, err_timeout
  );

  modport slave (
    input  wen, waddr, wdata, wstrb, ren, raddr,
    output wready, rdata, rvalid, err, err_timeout
  );
endinterface : lb_bus_if

interface apb_bus_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int STRB_W = DATA_W / 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface : apb_bus_if

// File: rtl/lb2apb_bridge.sv
// Local Bus to APB master bridge: one APB transfer per Local Bus request,
// write priority, fully registered outputs, optional ACCESS-phase timeout.
module lb2apb_bridge
  import lb2apb_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter int                STRB_W    = DATA_W / 8,
  parameter int                TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA = {DATA_W{1'b1}}
) (
  input  logic      clk,
  input  logic      rst,
  lb_bus_if.slave   lb,
  apb_bus_if.master apb
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            r_state,   w_state_nx;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nx;
  logic              r_psel,    w_psel_nx;
  logic              r_penable, w_penable_nx;
  logic              r_pwrite,  w_pwrite_nx;
  logic [ADDR_W-1:0] r_paddr,   w_paddr_nx;
  logic [DATA_W-1:0] r_pwdata,  w_pwdata_nx;
  logic [STRB_W-1:0] r_pstrb,   w_pstrb_nx;
  logic              r_wready,  w_wready_nx;
  logic              r_rvalid,  w_rvalid_nx;
  logic [DATA_W-1:0] r_rdata,   w_rdata_nx;
  logic              r_err,     w_err_nx;
  logic              r_err_to,  w_err_to_nx;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_psel_nx    = r_psel;
    w_penable_nx = r_penable;
    w_pwrite_nx  = r_pwrite;
    w_paddr_nx   = r_paddr;
    w_pwdata_nx  = r_pwdata;
    w_pstrb_nx   = r_pstrb;
    w_rdata_nx   = r_rdata;
    w_wready_nx  = 1'b0;
    w_rvalid_nx  = 1'b0;
    w_err_nx     = 1'b0;
    w_err_to_nx  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (lb.wen) begin
          w_paddr_nx  = lb.waddr;
          w_pwdata_nx = lb.wdata;
          w_pstrb_nx  = lb.wstrb;
          w_pwrite_nx = DIR_WRITE;
          w_psel_nx   = 1'b1;
          w_cnt_nx    = '0;
          w_state_nx  = ST_SETUP;
        end else if (lb.ren) begin
          w_paddr_nx  = lb.raddr;
          w_pstrb_nx  = '0;
          w_pwrite_nx = DIR_READ;
          w_psel_nx   = 1'b1;
          w_cnt_nx    = '0;
          w_state_nx  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        w_penable_nx = 1'b1;
        w_state_nx   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (apb.pready) begin
          w_psel_nx    = 1'b0;
          w_penable_nx = 1'b0;
          w_wready_nx  = (r_pwrite == DIR_WRITE);
          w_rvalid_nx  = (r_pwrite == DIR_READ);
          w_err_nx     = apb.pslverr;
          if (r_pwrite == DIR_READ) w_rdata_nx = apb.prdata;
          w_state_nx   = ST_RESP;
        end else if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
          // This is the TIMEOUT-th ACCESS cycle without pready: give up.
          w_psel_nx    = 1'b0;
          w_penable_nx = 1'b0;
          w_wready_nx  = (r_pwrite == DIR_WRITE);
          w_rvalid_nx  = (r_pwrite == DIR_READ);
          w_err_nx     = 1'b1;
          w_err_to_nx  = 1'b1;
          if (r_pwrite == DIR_READ) w_rdata_nx = ERR_RDATA;
          w_state_nx   = ST_RESP;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end

      ST_RESP: w_state_nx = ST_IDLE;

      default: w_state_nx = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_wready  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_psel    <= w_psel_nx;
      r_penable <= w_penable_nx;
      r_pwrite  <= w_pwrite_nx;
      r_paddr   <= w_paddr_nx;
      r_pwdata  <= w_pwdata_nx;
      r_pstrb   <= w_pstrb_nx;
      r_wready  <= w_wready_nx;
      r_rvalid  <= w_rvalid_nx;
      r_rdata   <= w_rdata_nx;
      r_err     <= w_err_nx;
      r_err_to  <= w_err_to_nx;
    end
  end

  assign apb.psel       = r_psel;
  assign apb.penable    = r_penable;
  assign apb.pwrite     = r_pwrite;
  assign apb.paddr      = r_paddr;
  assign apb.pwdata     = r_pwdata;
  assign apb.pstrb      = r_pstrb;
  assign lb.wready      = r_wready;
  assign lb.rvalid      = r_rvalid;
  assign lb.rdata       = r_rdata;
  assign lb.err         = r_err;
  assign lb.err_timeout = r_err_to;

endmodule : lb2apb_bridge

// File: tb/tb_lb2apb_bridge.sv
// Self-checking bench for lb2apb_bridge: directed cases plus randomized
// transfers against a transaction-level model with a backing memory.
module tb_lb2apb_bridge;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lb_bus_if  #(.ADDR_W(8), .DATA_W(8)) lb ();
  apb_bus_if #(.ADDR_W(8), .DATA_W(8)) apb ();

  lb2apb_bridge #(
    .ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT), .ERR_RDATA(8'hFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lb (lb),
    .apb(apb)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mem [256];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One complete transfer. The request is raised now (cycle 0 is the IDLE
  // cycle ending at the next posedge); the bench also plays an APB slave that
  // raises pready after `waits` ACCESS cycles. Returns at the IDLE cycle that
  // follows the response.
  task automatic run_xfer(input bit is_wr, input logic [7:0] addr, input logic [7:0] data,
                          input logic strb, input int waits, input bit slverr);
    bit         to;
    bit         err_exp;
    int         resp_cyc;
    int         acc;
    logic [7:0] exp_rd;
    to       = (waits >= TIMEOUT);
    err_exp  = to || slverr;
    resp_cyc = to ? 2 + TIMEOUT : 3 + waits;
    exp_rd   = to ? 8'hFF : mem[addr];
    acc      = 0;
    if (is_wr) begin
      lb.wen = 1'b1; lb.waddr = addr; lb.wdata = data; lb.wstrb = strb;
    end else begin
      lb.ren = 1'b1; lb.raddr = addr;
    end
    for (int cyc = 1; cyc <= resp_cyc + 1; cyc++) begin
      @(negedge clk);
      check("psel", apb.psel, (cyc < resp_cyc));
      check("penable", apb.penable, (cyc >= 2 && cyc < resp_cyc));
      if (cyc < resp_cyc) begin
        check("paddr", apb.paddr, addr);
        check("pwrite", apb.pwrite, is_wr);
        check("pstrb", apb.pstrb, is_wr ? strb : 1'b0);
        if (is_wr) check("pwdata", apb.pwdata, data);
      end
      check("resp{wready,rvalid,err,err_to}", {lb.wready, lb.rvalid, lb.err, lb.err_timeout},
            (cyc == resp_cyc) ? {is_wr, !is_wr, err_exp, to} : 4'b0000);
      if (cyc == resp_cyc && !is_wr) check("rdata", lb.rdata, exp_rd);

      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
      apb.prdata  = 8'($urandom);
      if (apb.psel && apb.penable) begin
        acc++;
        if (acc == waits + 1) begin
          apb.pready  = 1'b1;
          apb.pslverr = slverr;
          apb.prdata  = mem[addr];
          if (is_wr && !slverr && strb) mem[addr] = data;
        end
      end
      if (cyc == resp_cyc) begin
        if (is_wr) lb.wen = 1'b0;
        else       lb.ren = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h5C;

    rst = 1'b1;
    lb.wen = 1'b0; lb.waddr = '0; lb.wdata = '0; lb.wstrb = '0;
    lb.ren = 1'b0; lb.raddr = '0;
    apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_apb", {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, apb.pstrb}, '0);
    check("reset_lb", {lb.wready, lb.rvalid, lb.err, lb.err_timeout, lb.rdata}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write, read with three wait states.
    run_xfer(1'b1, 8'h24, 8'hA5, 1'b1, 0, 1'b0);
    run_xfer(1'b0, 8'h10, 8'h00, 1'b0, 3, 1'b0);

    // Both requests at once: write first, held read follows.
    lb.ren = 1'b1; lb.raddr = 8'h24;
    run_xfer(1'b1, 8'h24, 8'h3C, 1'b1, 0, 1'b0);
    run_xfer(1'b0, 8'h24, 8'h00, 1'b0, 1, 1'b0);

    // Slave error on write, then timeout on read.
    run_xfer(1'b1, 8'h40, 8'h99, 1'b1, 2, 1'b1);
    run_xfer(1'b0, 8'h77, 8'h00, 1'b0, 10, 1'b0);
    // pready on the last allowed ACCESS cycle wins over the timeout.
    run_xfer(1'b0, 8'h10, 8'h00, 1'b0, TIMEOUT - 1, 1'b0);

    // Reset while penable is high, then a normal write.
    lb.wen = 1'b1; lb.waddr = 8'h33; lb.wdata = 8'h11; lb.wstrb = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_penable", apb.penable, 1'b1);
    rst = 1'b1;
    #1;
    check("async_reset_outs", {apb.psel, apb.penable, lb.wready, lb.rvalid}, 4'b0000);
    lb.wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_xfer(1'b1, 8'h33, 8'h6E, 1'b1, 1, 1'b0);
    run_xfer(1'b0, 8'h33, 8'h00, 1'b0, 0, 1'b0);

    // Randomized traffic over a small address window so reads hit writes.
    for (int n = 0; n < 60; n++) begin
      bit         wr;
      logic [7:0] a;
      int         w;
      wr = 1'($urandom_range(0, 1));
      a  = {4'h5, 4'($urandom_range(0, 15))};
      w  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
      run_xfer(wr, a, 8'($urandom), 1'($urandom_range(0, 3) != 0), w,
               ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_lb2apb_bridge
